wb_write_scheduler: RTL and testbench

Sequences register-file writes coming out of the writeback stage onto the single register-file write port. Instructions that retire two destination writes in one cycle (SWAP, double-register POP) are serialized through a small in-order pending queue, and the block back-pressures the pipeline with `stall` when the queue cannot absorb another instruction. It also owns the output-port register updated by OUT instructions. It sits between the writeback stage and the register file.

---
 rtl/wb_write_scheduler_pkg.sv | 21 ++
 rtl/wb_write_scheduler_if.sv | 55 +++++
 rtl/wb_write_scheduler_pending_fifo.sv | 74 +++++++
 rtl/wb_write_scheduler.sv | 144 ++++++++++++++
 tb/tb_wb_write_scheduler.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_sched_pkg
//  Purpose  : Shared defaults and the write-request record used by the
//             writeback write scheduler and its bench.
//  Contents : DATA_W_DEF, ADDR_W_DEF, DEPTH_DEF, wb_req_t {rd, data}
//  Revision : 1.0 - initial release
// ============================================================================
package wb_sched_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;
   localparam int DEPTH_DEF  = 4;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] rd;
      logic [DATA_W_DEF-1:0] data;
   } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_write_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_write_scheduler_if
//  Purpose  : Writeback-side request bus, register-file write port and
//             output port of the write scheduler, bundled as one interface.
//  Modports : master - writeback stage / decode side (drives requests)
//             slave  - the scheduler
//  Options  : WB_FWD_EN adds fwd_rd / fwd_hit / fwd_data
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_write_scheduler_if #(
   parameter int DATA_W = wb_sched_pkg::DATA_W_DEF,
   parameter int ADDR_W = wb_sched_pkg::ADDR_W_DEF
);
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic              wb2_valid;
   logic [ADDR_W-1:0] wb2_rd;
   logic [DATA_W-1:0] wb2_data;
   logic              out_en;
   logic [DATA_W-1:0] out_data;
   logic              stall;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] out_port;
`ifdef WB_FWD_EN
   logic [ADDR_W-1:0] fwd_rd;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;
`endif

   modport master (
      output wb_valid, wb_rd, wb_data, wb2_valid, wb2_rd, wb2_data,
      output out_en, out_data,
`ifdef WB_FWD_EN
      output fwd_rd,
      input  fwd_hit, fwd_data,
`endif
      input  stall, rf_we, rf_waddr, rf_wdata, out_port
   );

   modport slave (
      input  wb_valid, wb_rd, wb_data, wb2_valid, wb2_rd, wb2_data,
      input  out_en, out_data,
`ifdef WB_FWD_EN
      input  fwd_rd,
      output fwd_hit, fwd_data,
`endif
      output stall, rf_we, rf_waddr, rf_wdata, out_port
   );

endinterface
`default_nettype wire

// File: rtl/wb_write_scheduler_pending_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pending_fifo
//  Purpose  : In-order circular buffer for deferred register writes.
//             Up to two pushes (a is older than b) and one pop per cycle.
//  Ports    : clk, rst (async, active-low)
//             i_push_a/i_data_a, i_push_b/i_data_b - pushes, a before b
//             i_pop - remove head; o_head - head entry; o_count - fill level
//             o_rd_ptr, o_mem - raw storage for the forwarding search
//  Options  : WB_FWD_EN exposes o_rd_ptr / o_mem
//  Revision : 1.0 - initial release
// ============================================================================
module wb_pending_fifo
   import wb_sched_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int W     = ADDR_W_DEF + DATA_W_DEF,
   parameter int CW    = $clog2(DEPTH + 1),
   parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_push_a,
   input  logic [W-1:0]            i_data_a,
   input  logic                    i_push_b,
   input  logic [W-1:0]            i_data_b,
   input  logic                    i_pop,
   output logic [W-1:0]            o_head,
`ifdef WB_FWD_EN
   output logic [PW-1:0]           o_rd_ptr,
   output logic [DEPTH-1:0][W-1:0] o_mem,
`endif
   output logic [CW-1:0]           o_count
);
   logic [DEPTH-1:0][W-1:0] r_mem;
   logic [PW-1:0]           r_wr;
   logic [PW-1:0]           r_rd;
   logic [CW-1:0]           r_count;
   logic [PW-1:0]           w_wr_b;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
   endfunction

   // Entry b lands right behind entry a, or at the tail if a is absent.
   assign w_wr_b = i_push_a ? f_inc(r_wr) : r_wr;

   always_ff @(posedge clk) begin
      if (i_push_a) r_mem[r_wr]   <= i_data_a;
      if (i_push_b) r_mem[w_wr_b] <= i_data_b;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         r_wr    <= i_push_b ? f_inc(w_wr_b) : w_wr_b;
         if (i_pop) r_rd <= f_inc(r_rd);
         r_count <= r_count + CW'(i_push_a) + CW'(i_push_b) - CW'(i_pop);
      end
   end

   assign o_head  = r_mem[r_rd];
   assign o_count = r_count;
`ifdef WB_FWD_EN
   assign o_rd_ptr = r_rd;
   assign o_mem    = r_mem;
`endif

endmodule
`default_nettype wire

// File: rtl/wb_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : wb_write_scheduler
//  Purpose  : Serialises one or two writeback writes per instruction onto the
//             single register-file write port, back-pressures the pipeline
//             through stall, and owns the OUT-instruction output register.
//  Ports    : clk, rst (async, active-low)
//             bus (slave) - wb/wb2 requests, out_en/out_data, stall,
//                           rf_we/rf_waddr/rf_wdata, out_port, [fwd_*]
//  Options  : WB_FWD_EN - forwarding search over in-flight writes
//  Revision : 1.0 - initial release
// ============================================================================
module wb_write_scheduler
   import wb_sched_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF    // must be >= 2
) (
   input  logic                clk,
   input  logic                rst,
   wb_write_scheduler_if.slave bus
);
   localparam int W  = ADDR_W + DATA_W;
   localparam int CW = $clog2(DEPTH + 1);
   // Above this fill level one more dual-write instruction could overflow.
   localparam logic [CW-1:0] c_STALL_TH = CW'(DEPTH - 2);

   logic              w_acc;
   logic              w_p_valid;
   logic              w_s_valid;
   logic              w_q_busy;
   logic              w_push_a;
   logic              w_push_b;
   logic [W-1:0]      w_p;
   logic [W-1:0]      w_s;
   logic [W-1:0]      w_head;
   logic [CW-1:0]     w_count;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_out;

   // Stall depends on registered count only.
   assign bus.stall = (w_count > c_STALL_TH);
   assign w_acc     = ~bus.stall;
   assign w_q_busy  = (w_count != '0);

   // A lone secondary request is promoted to the primary slot.
   assign w_p_valid = bus.wb_valid | bus.wb2_valid;
   assign w_s_valid = bus.wb_valid & bus.wb2_valid;
   assign w_p       = bus.wb_valid ? {bus.wb_rd, bus.wb_data}
                                   : {bus.wb2_rd, bus.wb2_data};
   assign w_s       = {bus.wb2_rd, bus.wb2_data};

   // With older writes queued the primary must queue behind them; with an
   // empty queue it bypasses and only the secondary is deferred.
   assign w_push_a  = w_acc & w_p_valid & w_q_busy;
   assign w_push_b  = w_acc & w_s_valid;

`ifdef WB_FWD_EN
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   logic [PW-1:0]           w_rd_ptr;
   logic [DEPTH-1:0][W-1:0] w_mem;
`endif

   wb_pending_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .i_push_a (w_push_a),
      .i_data_a (w_p),
      .i_push_b (w_push_b),
      .i_data_b (w_s),
      .i_pop    (w_q_busy),
      .o_head   (w_head),
`ifdef WB_FWD_EN
      .o_rd_ptr (w_rd_ptr),
      .o_mem    (w_mem),
`endif
      .o_count  (w_count)
   );

   // Queue head has priority on the write port; otherwise the bypass.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else if (w_q_busy) begin
         r_we    <= 1'b1;
         r_waddr <= w_head[DATA_W +: ADDR_W];
         r_wdata <= w_head[DATA_W-1:0];
      end else if (w_acc && w_p_valid) begin
         r_we    <= 1'b1;
         r_waddr <= w_p[DATA_W +: ADDR_W];
         r_wdata <= w_p[DATA_W-1:0];
      end else begin
         r_we    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out <= '0;
      end else if (w_acc && bus.out_en) begin
         r_out <= bus.out_data;
      end
   end

   assign bus.rf_we    = r_we;
   assign bus.rf_waddr = r_waddr;
   assign bus.rf_wdata = r_wdata;
   assign bus.out_port = r_out;

`ifdef WB_FWD_EN
   // Scan oldest to youngest (rf register, then queue head to tail) so the
   // last match, i.e. the youngest write, wins.
   always_comb begin
      int w_idx;
      w_idx        = 0;
      bus.fwd_hit  = 1'b0;
      bus.fwd_data = '0;
      if (r_we && (r_waddr == bus.fwd_rd)) begin
         bus.fwd_hit  = 1'b1;
         bus.fwd_data = r_wdata;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < w_count) begin
            w_idx = int'(w_rd_ptr) + i;
            if (w_idx >= DEPTH) w_idx = w_idx - DEPTH;
            if (w_mem[PW'(w_idx)][DATA_W +: ADDR_W] == bus.fwd_rd) begin
               bus.fwd_hit  = 1'b1;
               bus.fwd_data = w_mem[PW'(w_idx)][DATA_W-1:0];
            end
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_write_scheduler
//  Purpose  : Self-checking bench for wb_write_scheduler: directed table,
//             mid-traffic reset, optional forwarding queries (WB_FWD_EN) and
//             randomised traffic against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_write_scheduler;
   import wb_sched_pkg::*;

   localparam int DATA_W = DATA_W_DEF;
   localparam int ADDR_W = ADDR_W_DEF;
   localparam int DEPTH  = DEPTH_DEF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_write_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   wb_write_scheduler #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic              wv;
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] d;
      logic              w2v;
      logic [ADDR_W-1:0] rd2;
      logic [DATA_W-1:0] d2;
      logic              oe;
      logic [DATA_W-1:0] od;
      logic              ewe;
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] ed;
      logic              est;
      logic [DATA_W-1:0] eo;
   } vec_t;

   vec_t              tbl[$];
   int                n_cmp = 0;
   int                n_bad = 0;
   // Reference model: the in-order list of writes still owed to the rf port.
   wb_req_t           mq[$];
   logic              m_we;
   logic [ADDR_W-1:0] m_a;
   logic [DATA_W-1:0] m_d;
   logic [DATA_W-1:0] m_out;
   logic [DATA_W-1:0] shadow[8];

   function automatic vec_t mk(logic wv, logic [2:0] rd, logic [15:0] d,
                               logic w2v, logic [2:0] rd2, logic [15:0] d2,
                               logic oe, logic [15:0] od, logic ewe,
                               logic [2:0] ea, logic [15:0] ed, logic est,
                               logic [15:0] eo);
      vec_t v;
      v.wv = wv; v.rd = rd; v.d = d; v.w2v = w2v; v.rd2 = rd2; v.d2 = d2;
      v.oe = oe; v.od = od; v.ewe = ewe; v.ea = ea; v.ed = ed;
      v.est = est; v.eo = eo;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(logic wv, logic [2:0] rd, logic [15:0] d, logic w2v,
                        logic [2:0] rd2, logic [15:0] d2, logic oe, logic [15:0] od);
      bus.wb_valid  = wv;  bus.wb_rd  = rd;  bus.wb_data  = d;
      bus.wb2_valid = w2v; bus.wb2_rd = rd2; bus.wb2_data = d2;
      bus.out_en    = oe;  bus.out_data = od;
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
   endtask

   // One clock: model consumes the current inputs, then DUT is compared.
   task automatic step();
      wb_req_t r;
      if (!(mq.size() > DEPTH - 2)) begin
         if (bus.wb_valid)  begin r.rd = bus.wb_rd;  r.data = bus.wb_data;  mq.push_back(r); end
         if (bus.wb2_valid) begin r.rd = bus.wb2_rd; r.data = bus.wb2_data; mq.push_back(r); end
         if (bus.out_en) m_out = bus.out_data;
      end
      if (mq.size() > 0) begin
         r = mq.pop_front();
         m_we = 1'b1; m_a = r.rd; m_d = r.data;
      end else begin
         m_we = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("rf_we", {31'b0, bus.rf_we}, {31'b0, m_we});
      if (m_we) begin
         chk("rf_waddr", {29'b0, bus.rf_waddr}, {29'b0, m_a});
         chk("rf_wdata", {16'b0, bus.rf_wdata}, {16'b0, m_d});
      end
      if (bus.rf_we === 1'b1) shadow[bus.rf_waddr] = bus.rf_wdata;
      chk("stall", {31'b0, bus.stall}, {31'b0, (mq.size() > DEPTH - 2)});
      chk("out_port", {16'b0, bus.out_port}, {16'b0, m_out});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 8; i++) shadow[i] = '0;
      m_we = 1'b0; m_a = '0; m_d = '0; m_out = '0;
      rst = 1'b0;
      idle();
`ifdef WB_FWD_EN
      bus.fwd_rd = '0;
`endif

      // Single writes
      tbl.push_back(mk(1,3'd1,16'h1234, 0,3'd0,16'h0, 0,16'h0, 1,3'd1,16'h1234, 0,16'h0000));
      tbl.push_back(mk(1,3'd2,16'hBEEF, 0,3'd0,16'h0, 0,16'h0, 1,3'd2,16'hBEEF, 0,16'h0000));
      tbl.push_back(mk(0,3'd0,16'h0,    0,3'd0,16'h0, 0,16'h0, 0,3'd0,16'h0,    0,16'h0000));
      // SWAP burst; stalled row repeats the last SWAP with out_en (ignored)
      tbl.push_back(mk(1,3'd1,16'hA001, 1,3'd2,16'hA002, 0,16'h0,    1,3'd1,16'hA001, 0,16'h0000));
      tbl.push_back(mk(1,3'd3,16'hB001, 1,3'd4,16'hB002, 0,16'h0,    1,3'd2,16'hA002, 0,16'h0000));
      tbl.push_back(mk(1,3'd5,16'hC001, 1,3'd6,16'hC002, 0,16'h0,    1,3'd3,16'hB001, 1,16'h0000));
      tbl.push_back(mk(1,3'd5,16'hC001, 1,3'd6,16'hC002, 1,16'h00FF, 1,3'd4,16'hB002, 0,16'h0000));
      tbl.push_back(mk(0,3'd0,16'h0,    0,3'd0,16'h0,    1,16'h00FF, 1,3'd5,16'hC001, 0,16'h00FF));
      tbl.push_back(mk(0,3'd0,16'h0,    0,3'd0,16'h0,    0,16'h0,    1,3'd6,16'hC002, 0,16'h00FF));
      tbl.push_back(mk(0,3'd0,16'h0,    0,3'd0,16'h0,    0,16'h0,    0,3'd0,16'h0,    0,16'h00FF));
      // Same-register pair, then a lone secondary
      tbl.push_back(mk(1,3'd3,16'h0001, 1,3'd3,16'h0002, 0,16'h0, 1,3'd3,16'h0001, 0,16'h00FF));
      tbl.push_back(mk(0,3'd0,16'h0,    0,3'd0,16'h0,    0,16'h0, 1,3'd3,16'h0002, 0,16'h00FF));
      tbl.push_back(mk(0,3'd0,16'h0,    1,3'd5,16'h5555, 0,16'h0, 1,3'd5,16'h5555, 0,16'h00FF));
      tbl.push_back(mk(0,3'd0,16'h0,    0,3'd0,16'h0,    0,16'h0, 0,3'd0,16'h0,    0,16'h00FF));

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rf_we",    {31'b0, bus.rf_we},    32'd0);
      chk("rst_rf_waddr", {29'b0, bus.rf_waddr}, 32'd0);
      chk("rst_rf_wdata", {16'b0, bus.rf_wdata}, 32'd0);
      chk("rst_out_port", {16'b0, bus.out_port}, 32'd0);
      chk("rst_stall",    {31'b0, bus.stall},    32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Directed table
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].wv, tbl[i].rd, tbl[i].d, tbl[i].w2v, tbl[i].rd2, tbl[i].d2,
               tbl[i].oe, tbl[i].od);
         step();
         chk($sformatf("tbl%0d_we", i), {31'b0, bus.rf_we}, {31'b0, tbl[i].ewe});
         if (tbl[i].ewe) begin
            chk($sformatf("tbl%0d_waddr", i), {29'b0, bus.rf_waddr}, {29'b0, tbl[i].ea});
            chk($sformatf("tbl%0d_wdata", i), {16'b0, bus.rf_wdata}, {16'b0, tbl[i].ed});
         end
         chk($sformatf("tbl%0d_stall", i), {31'b0, bus.stall}, {31'b0, tbl[i].est});
         chk($sformatf("tbl%0d_out", i), {16'b0, bus.out_port}, {16'b0, tbl[i].eo});
      end
      chk("same_reg_final_r3", {16'b0, shadow[3]}, 32'h0002);

`ifdef WB_FWD_EN
      // rf register ends up holding R4=0x1111, queue holds R4=0x2222 behind it
      drive(1, 3'd7, 16'h0777, 1, 3'd4, 16'h1111, 0, 16'h0);
      step();
      drive(1, 3'd4, 16'h2222, 1, 3'd6, 16'h0666, 0, 16'h0);
      step();
      idle();
      bus.fwd_rd = 3'd4;
      #1;
      chk("fwd_r4_hit",  {31'b0, bus.fwd_hit},  32'd1);
      chk("fwd_r4_data", {16'b0, bus.fwd_data}, 32'h2222);
      bus.fwd_rd = 3'd5;
      #1;
      chk("fwd_r5_hit",  {31'b0, bus.fwd_hit},  32'd0);
      bus.fwd_rd = 3'd6;
      #1;
      chk("fwd_r6_data", {16'b0, bus.fwd_data}, 32'h0666);
      repeat (3) step();
`endif

      // Mid-traffic reset: fill to stall with out_port loaded, then reset
      drive(1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, 1, 16'h5A5A);
      step();
      drive(1, 3'd3, 16'h3333, 1, 3'd4, 16'h4444, 0, 16'h0);
      step();
      drive(1, 3'd5, 16'h5555, 1, 3'd6, 16'h6666, 0, 16'h0);
      step();
      chk("pre_rst_stall", {31'b0, bus.stall}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_rf_we",    {31'b0, bus.rf_we},    32'd0);
      chk("mid_rst_out_port", {16'b0, bus.out_port}, 32'd0);
      chk("mid_rst_stall",    {31'b0, bus.stall},    32'd0);
      mq.delete();
      m_we = 1'b0; m_out = '0;
      @(negedge clk);
      rst = 1'b1;
      drive(1, 3'd2, 16'h4242, 0, 3'd0, 16'h0, 0, 16'h0);
      step();
      chk("post_rst_first_we",   {31'b0, bus.rf_we},    32'd1);
      chk("post_rst_first_data", {16'b0, bus.rf_wdata}, 32'h4242);
      idle();
      step();

      // Randomised traffic; inputs are held while the model says stalled
      for (int n = 0; n < 400; n++) begin
         if (!(mq.size() > DEPTH - 2)) begin
            drive(($urandom % 4) != 0, 3'($urandom), 16'($urandom),
                  ($urandom % 3) == 0, 3'($urandom), 16'($urandom),
                  ($urandom % 5) == 0, 16'($urandom));
         end
         step();
      end
      idle();
      repeat (DEPTH + 2) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
